// File: rtl/kws_pkg.sv
// Shared definitions for the keyword-spotting feature window: the FSM state
// encoding, default feature geometry and the stride clamping rule.
package kws_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2
  } kws_state_t;

  localparam int MFCC_FEATURES_DEFAULT = 40;
  localparam int ACTIV_BITS_DEFAULT    = 8;

  // Stride is never below one frame and never above the largest window size;
  // it is further capped by the instance's actual window length.
  localparam int unsigned STRIDE_MIN = 1;
  localparam int unsigned STRIDE_MAX = 64;

  function automatic int unsigned clamp_stride(input logic [7:0] cfg,
                                               input int unsigned num_frames);
    int unsigned c;
    int unsigned lim;
    c   = {24'd0, cfg};
    lim = (num_frames < STRIDE_MAX) ? num_frames : STRIDE_MAX;
    if (c < STRIDE_MIN) return STRIDE_MIN;
    if (c > lim) return lim;
    return c;
  endfunction

endpackage

// File: rtl/kws_frame_ram.sv
// Frame history storage: one write port, one registered read port. The array
// is never reset; only the read register is cleared so the window output
// starts at zero.
module kws_frame_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 320
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write accepted frames into the circular history.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value whenever no read is requested.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kws_feature_window.sv
// Sliding window of MFCC frames: collects frames into a circular history and,
// once enough new frames have arrived, streams NUM_FRAMES frames oldest-first
// to the downstream CNN with valid/ready handshaking.
module kws_feature_window
  import kws_pkg::*;
#(
  parameter int MFCC_FEATURES = MFCC_FEATURES_DEFAULT,
  parameter int ACTIV_BITS    = ACTIV_BITS_DEFAULT,
  parameter int NUM_FRAMES    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [MFCC_FEATURES*ACTIV_BITS-1:0] frame_in,
  input  logic                                frame_valid,
  output logic                                frame_ready,
  input  logic [7:0]                          cfg_stride,
  input  logic                                flush,
  output logic [MFCC_FEATURES*ACTIV_BITS-1:0] win_data,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic                                win_first,
  output logic                                win_last,
  output logic [15:0]                         window_count
);

  localparam int W  = MFCC_FEATURES * ACTIV_BITS;
  localparam int AW = $clog2(NUM_FRAMES);
  localparam int CW = AW + 1;

  kws_state_t    state_reg, state_next;
  logic [AW-1:0] wptr_reg, rptr_reg, beat_reg;
  logic [CW-1:0] cnt_reg, stride_reg, limit;
  logic          valid_reg, first_reg, last_reg;
  logic [15:0]   count_reg;
  logic          accept, handshake, complete, end_window, re;
  logic [AW-1:0] raddr;

  // Accept/handshake qualification; flush always takes priority over both.
  always_comb begin
    accept     = frame_valid && frame_ready && !flush;
    handshake  = valid_reg && win_ready;
    limit      = (state_reg == FILL) ? CW'(NUM_FRAMES - 1) : (stride_reg - CW'(1));
    complete   = accept && (cnt_reg == limit);
    end_window = handshake && last_reg && !flush;
    // The completing accept reads the oldest frame (the slot just past the
    // one being written); later beats read from the running read pointer.
    re         = complete || (handshake && !last_reg && !flush);
    raddr      = complete ? (wptr_reg + AW'(1)) : rptr_reg;
  end

  // Next-state logic for the FILL / COLLECT / STREAM sequence.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = FILL;
    end else begin
      case (state_reg)
        FILL, COLLECT: if (complete) state_next = STREAM;
        STREAM:        if (end_window) state_next = COLLECT;
        default:       state_next = FILL;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= FILL;
    else        state_reg <= state_next;
  end

  // Pointers, counters, stride latch and the output beat flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      beat_reg   <= '0;
      cnt_reg    <= '0;
      stride_reg <= CW'(1);
      valid_reg  <= 1'b0;
      first_reg  <= 1'b0;
      last_reg   <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (accept) wptr_reg <= wptr_reg + AW'(1);
      if (flush) begin
        cnt_reg    <= '0;
        beat_reg   <= '0;
        valid_reg  <= 1'b0;
        first_reg  <= 1'b0;
        last_reg   <= 1'b0;
        stride_reg <= CW'(clamp_stride(cfg_stride, NUM_FRAMES));
      end else if (complete) begin
        cnt_reg   <= '0;
        beat_reg  <= '0;
        valid_reg <= 1'b1;
        first_reg <= 1'b1;
        last_reg  <= 1'b0;
        rptr_reg  <= wptr_reg + AW'(2);
      end else if (accept) begin
        cnt_reg <= cnt_reg + CW'(1);
      end else if (handshake) begin
        if (last_reg) begin
          valid_reg  <= 1'b0;
          last_reg   <= 1'b0;
          count_reg  <= count_reg + 16'd1;
          stride_reg <= CW'(clamp_stride(cfg_stride, NUM_FRAMES));
        end else begin
          beat_reg  <= beat_reg + AW'(1);
          rptr_reg  <= rptr_reg + AW'(1);
          first_reg <= 1'b0;
          last_reg  <= (beat_reg + AW'(1)) == AW'(NUM_FRAMES - 1);
        end
      end
    end
  end

  kws_frame_ram #(
    .DEPTH(NUM_FRAMES),
    .WIDTH(W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (accept),
    .waddr(wptr_reg),
    .wdata(frame_in),
    .re   (re),
    .raddr(raddr),
    .rdata(win_data)
  );

  assign frame_ready  = rst_n && (state_reg != STREAM);
  assign win_valid    = valid_reg;
  assign win_first    = first_reg;
  assign win_last     = last_reg;
  assign window_count = count_reg;

endmodule

// File: doc/kws_feature_window.md
KWS_FEATURE_WINDOW -- requirements
Module: kws_feature_window

Interface
- REQ-001 SHALL have parameter MFCC_FEATURES, default 40: coefficients per frame.
- REQ-002 SHALL have parameter ACTIV_BITS, default 8: bits per coefficient.
- REQ-003 SHALL have parameter NUM_FRAMES, default 16: frames per window, power of two, 2..64.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-006 SHALL have port frame_in, input, MFCC_FEATURES*ACTIV_BITS bits: one MFCC frame.
- REQ-007 SHALL have port frame_valid, input, 1 bit: frame_in is valid.
- REQ-008 SHALL have port frame_ready, output, 1 bit: the block accepts frame_in.
- REQ-009 SHALL have port cfg_stride, input, 8 bits: new frames required between windows.
- REQ-010 SHALL have port flush, input, 1 bit: abandon the current window and history.
- REQ-011 SHALL have port win_data, output, MFCC_FEATURES*ACTIV_BITS bits: window frame, oldest first.
- REQ-012 SHALL have port win_valid, output, 1 bit: win_data is valid.
- REQ-013 SHALL have port win_ready, input, 1 bit: the downstream CNN accepts win_data.
- REQ-014 SHALL have ports win_first and win_last, outputs, 1 bit each: marks on beat 0 and beat NUM_FRAMES-1.
- REQ-015 SHALL have port window_count, output, 16 bits: windows fully emitted; wraps at 2^16.

Function
- REQ-016 SHALL store frames in a circular buffer of NUM_FRAMES entries with write pointer wptr, which wraps modulo NUM_FRAMES.
- REQ-017 SHALL accept a frame when frame_valid and frame_ready are both high; the accepted frame is written at wptr and wptr increments.
- REQ-018 SHALL implement the FSM states FILL, COLLECT and STREAM; reset and flush both enter FILL.
- REQ-019 In FILL, frame_ready SHALL be 1; the block SHALL move to STREAM after the edge that accepts the NUM_FRAMES-th frame since entering FILL.
- REQ-020 In COLLECT, frame_ready SHALL be 1; the block SHALL move to STREAM after the edge that accepts the S-th frame since entering COLLECT, where S is the latched stride.
- REQ-021 S SHALL be latched from cfg_stride on every entry to FILL or COLLECT; a value of 0 SHALL be treated as 1, and values above NUM_FRAMES SHALL be clamped to NUM_FRAMES.
- REQ-022 In STREAM, frame_ready SHALL be 0 (backpressure); the read pointer SHALL start at the wptr value on entry, which is the oldest frame.
- REQ-023 win_valid SHALL rise in the first cycle after the transition into STREAM, giving one cycle of latency from the completing accept.
- REQ-024 win_data SHALL be registered and SHALL hold stable while win_valid is high and win_ready is low.
- REQ-025 Each win_valid and win_ready handshake SHALL advance the read pointer modulo NUM_FRAMES.
- REQ-026 Back-to-back beats SHALL sustain one per cycle while win_ready is held high.
- REQ-027 After the handshake on the win_last beat:
  - win_valid SHALL fall the next cycle;
  - window_count SHALL increment;
  - the FSM SHALL enter COLLECT.
- REQ-028 Buffer contents SHALL NOT change during STREAM, so an emitted window is always NUM_FRAMES consecutive accepted frames.
- REQ-029 When flush is high at an edge, the block SHALL:
  - return to FILL;
  - clear the frame counters;
  - drop win_valid the next cycle, discarding any partial window without incrementing window_count;
  - take no frame from frame_in that cycle.
- REQ-030 When flush and a handshake coincide, flush SHALL win.
- REQ-031 window_count SHALL be cleared only by reset and not by flush.

Reset
- REQ-032 While rst_n is low at an edge, the block SHALL set:
  - state to FILL;
  - wptr, read pointer and counters to 0;
  - S to 1;
  - win_valid, win_first and win_last to 0;
  - window_count to 0;
  - win_data to 0.
- REQ-033 frame_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
- REQ-034 A reset asserted mid-STREAM SHALL terminate the window immediately, with no further beats.
- REQ-035 Buffer RAM contents SHALL NOT require reset.

Structure
- REQ-036 The shared package kws_pkg SHALL hold:
  - the state encoding (FILL=0, COLLECT=1, STREAM=2);
  - the MFCC_FEATURES and ACTIV_BITS defaults;
  - the clamp limit for stride.
- REQ-037 The storage SHALL be one sub-module, kws_frame_ram: NUM_FRAMES x MFCC_FEATURES*ACTIV_BITS, one write port, one registered read port.
- REQ-038 All control logic SHALL reside in kws_feature_window.

Verification (NUM_FRAMES=16, MFCC_FEATURES=40, ACTIV_BITS=8)
- REQ-039 Fill: cfg_stride=4, frames tagged 0..15 with win_ready held high -> win_valid rises one cycle after frame 15 is accepted; 16 consecutive beats carry tags 0..15; win_first on tag 0, win_last on tag 15; window_count=1.
- REQ-040 Stride: after the fill scenario, 4 more frames (16..19) -> window carries tags 4..19; frame_ready=0 for all 16 beats; window_count=2.
- REQ-041 Backpressure: win_ready toggles 1,0,0,1 repeatedly during STREAM -> win_data is stable while stalled; no beat is duplicated or skipped; beat order is unchanged.
- REQ-042 Stride edge values:
  - cfg_stride=0 -> a window after every accepted frame;
  - cfg_stride=200 -> clamped to 16, giving non-overlapping windows.
- REQ-043 Flush at beat 7 of a window -> win_valid=0 next cycle; window_count is unchanged; 16 fresh frames are required before the next window.
- REQ-044 rst_n low for 1 cycle mid-STREAM -> all outputs are at reset values the next cycle; frame_ready=1 the cycle after release; window_count=0.
